// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

   localparam int unsigned ROW_W    = 3;
   localparam int unsigned NUM_ROWS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      STORE  = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Row {in1,in2,in3} = r lands in truth-table bit (7 - r), so row 000 is the MSB.
   function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] row);
      return ROW_W'(NUM_ROWS - 1) - row;
   endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk   in  clock
//   rst_n in  synchronous active-low reset, clears both flops
//   d     in  asynchronous input
//   q     out synchronised output
module tt_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Stimulus-and-capture stage for 3-input gate cores: sweeps {in1,in2,in3}
// through 000..111, majority-votes the synchronised gate output for each row,
// assembles an 8-bit truth table and compares it with EXPECTED.
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   start        in   one-cycle pulse, accepted in IDLE or DONE
//   in1,in2,in3  out  gate stimulus, in1 is the row MSB
//   dut_out      in   gate output, asynchronous to clk
//   busy         out  sweep in progress
//   done         out  one-cycle pulse on entry to DONE
//   pass         out  truth_table == EXPECTED, valid in DONE
//   truth_table  out  assembled code, held until the next accepted start
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned SAMPLES       = 5,
   parameter logic [7:0]  EXPECTED      = 8'h06,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] truth_table
);

   localparam int unsigned ONES_W = $clog2(SAMPLES + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
   localparam logic [ONES_W-1:0] MAJ_THR     = ONES_W'(SAMPLES / 2);
   localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(NUM_ROWS - 1);

   // Elaboration-time parameter sanity.
   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 1");
   end
   if ((SAMPLES < 1) || ((SAMPLES % 2) == 0)) begin : g_bad_samples
      $error("SAMPLES must be odd and >= 1");
   end
   if (((1 << CNT_W) <= SETTLE_CYCLES) || ((1 << CNT_W) <= SAMPLES)) begin : g_bad_cnt
      $error("CNT_W too narrow for SETTLE_CYCLES/SAMPLES");
   end

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ONES_W-1:0]  ones_q, ones_d;
   logic [ROW_W-1:0]   stim_q, stim_d;
   logic [7:0]         tt_d;
   logic               busy_d, done_d, pass_d;
   logic               sync_out;
   logic               vote_c;

   // dut_out is never used before it has crossed into the clk domain.
   tt_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dut_out),
      .q     (sync_out)
   );

   assign vote_c = (ones_q > MAJ_THR);
   assign {in1, in2, in3} = stim_q;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
         cnt_q       <= '0;
         ones_q      <= '0;
         stim_q      <= '0;
         truth_table <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         ones_q      <= ones_d;
         stim_q      <= stim_d;
         truth_table <= tt_d;
         busy        <= busy_d;
         done        <= done_d;
         pass        <= pass_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      ones_d  = ones_q;
      stim_d  = stim_q;
      tt_d    = truth_table;
      busy_d  = busy;
      done_d  = 1'b0;
      pass_d  = pass;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               row_d   = '0;
               tt_d    = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = APPLY;
            end
         end

         APPLY: begin
            stim_d  = row_q;
            cnt_d   = '0;
            ones_d  = '0;
            state_d = SETTLE;
         end

         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         SAMPLE: begin
            ones_d = ones_q + ONES_W'(sync_out);
            if (cnt_q == SAMPLE_LAST) begin
               cnt_d   = '0;
               state_d = STORE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         STORE: begin
            tt_d[row_bit(row_q)] = vote_c;
            if (row_q == LAST_ROW) begin
               // pass compares the completed table, including this last bit.
               pass_d  = (tt_d == EXPECTED);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               row_d   = row_q + ROW_W'(1);
               state_d = APPLY;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
